alu_arbiter: RTL and testbench

Shares one instance of the core ALU between two requesters: port 0 is the execute stage and port 1 is the branch/compare unit. Each port uses a valid/ready request channel and a valid/ready response channel. Requests are arbitrated round-robin, the selected operands drive the shared ALU combinationally, and the result and jump condition are captured in a one-entry output register tagged with the owning port. Saturating per-port grant counters are exported for performance monitoring.

---
 rtl/alu_arbiter_pkg.sv | 31 +++
 rtl/alu_arbiter_alu.sv | 58 +++++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice: datapath/control widths,
//   requester port indices, the ALU control code enumeration and a small
//   helper that turns a port index into a one-hot per-port vector.
package alu_arbiter_pkg;

  localparam int ALU_ctrl_bus = 3;
  localparam int InstBus      = 32;

  // Requester port indices: execute stage and branch/compare unit.
  localparam logic PORT_EXE = 1'b0;
  localparam logic PORT_BR  = 1'b1;

  // ALU control codes; the same code also selects the jump condition.
  typedef enum logic [ALU_ctrl_bus-1:0] {
    ALU_ADD  = 3'd0,  // jc: eq
    ALU_SLL  = 3'd1,  // jc: ne
    ALU_SLT  = 3'd2,  // jc: 0
    ALU_SLTU = 3'd3,  // jc: 0
    ALU_XOR  = 3'd4,  // jc: lt
    ALU_SR   = 3'd5,  // jc: ge
    ALU_OR   = 3'd6,  // jc: ltu
    ALU_AND  = 3'd7   // jc: geu
  } alu_op_e;

  // One-hot per-port vector for a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    port_onehot = port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
//   Purely combinational core ALU datapath shared by the arbiter.
//   Ports:
//     op1, op2  : 32-bit operands
//     alu_ctrl  : 3-bit control code (result and jump-condition select)
//     sub       : subtract instead of add for code 0
//     sign      : arithmetic instead of logical right shift for code 5
//     result    : ALU result
//     jc        : jump condition
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [InstBus-1:0]      op1,
  input  logic [InstBus-1:0]      op2,
  input  logic [ALU_ctrl_bus-1:0] alu_ctrl,
  input  logic                    sub,
  input  logic                    sign,
  output logic [InstBus-1:0]      result,
  output logic                    jc
);

  logic [4:0]         shamt_s;
  logic [InstBus-1:0] sum_s;
  logic [InstBus-1:0] srl_s;
  logic [InstBus-1:0] sra_s;
  logic               eq_s;
  logic               lt_s;
  logic               ltu_s;

  // Shared sub-results: adder, shifts and the three comparisons.
  always_comb begin
    shamt_s = op2[4:0];
    sum_s   = sub ? (op1 - op2) : (op1 + op2);
    srl_s   = op1 >> shamt_s;
    sra_s   = $unsigned($signed(op1) >>> shamt_s);
    eq_s    = (op1 == op2);
    lt_s    = ($signed(op1) < $signed(op2));
    ltu_s   = (op1 < op2);
  end

  // Result and jump-condition select by control code.
  always_comb begin
    result = {InstBus{1'b0}};
    jc     = 1'b0;
    case (alu_op_e'(alu_ctrl))
      ALU_ADD:  begin result = sum_s;                 jc = eq_s;   end
      ALU_SLL:  begin result = op1 << shamt_s;        jc = !eq_s;  end
      ALU_SLT:  begin result = {31'd0, lt_s};         jc = 1'b0;   end
      ALU_SLTU: begin result = {31'd0, ltu_s};        jc = 1'b0;   end
      ALU_XOR:  begin result = op1 ^ op2;             jc = lt_s;   end
      ALU_SR:   begin result = sign ? sra_s : srl_s;  jc = !lt_s;  end
      ALU_OR:   begin result = op1 | op2;             jc = ltu_s;  end
      ALU_AND:  begin result = op1 & op2;             jc = !ltu_s; end
      default:  begin result = {InstBus{1'b0}};       jc = 1'b0;   end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one core ALU between the execute stage (port 0) and the
//   branch/compare unit (port 1). Requests are arbitrated round-robin, the
//   winner's operands drive the ALU combinationally, and the result and jump
//   condition are captured in a single output slot tagged with its owner.
//   Ports:
//     clk, rst_n                : clock, async active-low reset
//     req_valid_i / req_ready_o : per-port request handshake (ready = grant)
//     op1_i*, op2_i*, alu_ctrl_i*, sub_i, sign_i : per-port ALU inputs
//     rsp_valid_o / rsp_ready_i : per-port response handshake
//     result_o, jc_o            : registered slot contents
//     grant_cnt0_o/1_o          : saturating per-port grant counters
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [InstBus-1:0]      op1_i0,
  input  logic [InstBus-1:0]      op1_i1,
  input  logic [InstBus-1:0]      op2_i0,
  input  logic [InstBus-1:0]      op2_i1,
  input  logic [ALU_ctrl_bus-1:0] alu_ctrl_i0,
  input  logic [ALU_ctrl_bus-1:0] alu_ctrl_i1,
  input  logic [1:0]              sub_i,
  input  logic [1:0]              sign_i,
  output logic [1:0]              rsp_valid_o,
  input  logic [1:0]              rsp_ready_i,
  output logic [InstBus-1:0]      result_o,
  output logic                    jc_o,
  output logic [CNT_W-1:0]        grant_cnt0_o,
  output logic [CNT_W-1:0]        grant_cnt1_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                    out_full_r;
  logic                    out_owner_r;
  logic [InstBus-1:0]      result_r;
  logic                    jc_r;
  logic                    rr_ptr_r;
  logic [CNT_W-1:0]        cnt0_r;
  logic [CNT_W-1:0]        cnt1_r;

  logic                    slot_free_s;
  logic                    drain_s;
  logic                    win_s;
  logic                    grant_s;
  logic [InstBus-1:0]      alu_op1_s;
  logic [InstBus-1:0]      alu_op2_s;
  logic [ALU_ctrl_bus-1:0] alu_ctrl_s;
  logic                    alu_sub_s;
  logic                    alu_sign_s;
  logic [InstBus-1:0]      alu_result_s;
  logic                    alu_jc_s;

  // The slot can take a new op when empty or when its owner drains it now.
  assign drain_s     = out_full_r & rsp_ready_i[out_owner_r];
  assign slot_free_s = !out_full_r | drain_s;

  // Winner select: a lone requester wins, a tie goes to rr_ptr, and with no
  // requester port 0 is selected so the mux is still defined.
  always_comb begin
    case (req_valid_i)
      2'b11:   win_s = rr_ptr_r;
      2'b10:   win_s = PORT_BR;
      2'b01:   win_s = PORT_EXE;
      default: win_s = PORT_EXE;
    endcase
  end

  assign grant_s     = slot_free_s & req_valid_i[win_s];
  assign req_ready_o = grant_s ? port_onehot(win_s) : 2'b00;

  // Operand mux feeding the shared ALU.
  always_comb begin
    if (win_s == PORT_BR) begin
      alu_op1_s  = op1_i1;
      alu_op2_s  = op2_i1;
      alu_ctrl_s = alu_ctrl_i1;
    end else begin
      alu_op1_s  = op1_i0;
      alu_op2_s  = op2_i0;
      alu_ctrl_s = alu_ctrl_i0;
    end
    alu_sub_s  = sub_i[win_s];
    alu_sign_s = sign_i[win_s];
  end

  alu_arbiter_alu u_alu (
    .op1      (alu_op1_s),
    .op2      (alu_op2_s),
    .alu_ctrl (alu_ctrl_s),
    .sub      (alu_sub_s),
    .sign     (alu_sign_s),
    .result   (alu_result_s),
    .jc       (alu_jc_s)
  );

  // Output slot and round-robin pointer; a grant refills the slot even while
  // it drains, otherwise a drain just empties it and the data is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_full_r  <= 1'b0;
      out_owner_r <= PORT_EXE;
      result_r    <= {InstBus{1'b0}};
      jc_r        <= 1'b0;
      rr_ptr_r    <= PORT_EXE;
    end else if (grant_s) begin
      out_full_r  <= 1'b1;
      out_owner_r <= win_s;
      result_r    <= alu_result_s;
      jc_r        <= alu_jc_s;
      rr_ptr_r    <= ~win_s;
    end else if (drain_s) begin
      out_full_r  <= 1'b0;
    end
  end

  // Saturating per-port grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else if (grant_s) begin
      if (win_s == PORT_EXE && cnt0_r != CNT_MAX) begin
        cnt0_r <= cnt0_r + CNT_ONE;
      end
      if (win_s == PORT_BR && cnt1_r != CNT_MAX) begin
        cnt1_r <= cnt1_r + CNT_ONE;
      end
    end
  end

  assign rsp_valid_o  = out_full_r ? port_onehot(out_owner_r) : 2'b00;
  assign result_o     = result_r;
  assign jc_o         = jc_r;
  assign grant_cnt0_o = cnt0_r;
  assign grant_cnt1_o = cnt1_r;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, sub, sign, rsp_valid, rsp_ready;
  logic [31:0] op1_0, op1_1, op2_0, op2_1, result;
  logic [2:0]  ctrl_0, ctrl_1;
  logic        jc;
  logic [CNT_W-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op1_i0(op1_0), .op1_i1(op1_1), .op2_i0(op2_0), .op2_i1(op2_1),
    .alu_ctrl_i0(ctrl_0), .alu_ctrl_i1(ctrl_1),
    .sub_i(sub), .sign_i(sign),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .result_o(result), .jc_o(jc),
    .grant_cnt0_o(cnt0), .grant_cnt1_o(cnt1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_full, m_owner, m_prio, m_jc;
  logic [31:0] m_res;
  int          m_cnt[2];
  logic [1:0]  m_grant;

  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c, input bit s, input bit sg);
    logic [31:0] r;
    bit          lts, ltu, j;
    int          sh;
    sh  = int'(b % 32);
    ltu = (a < b);
    lts = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
    case (c)
      3'd0: r = s ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = lts ? 32'd1 : 32'd0;
      3'd3: r = ltu ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = (sg && a[31]) ? ~((~a) >> sh) : (a >> sh);
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    case (c)
      3'd0: j = (a == b);
      3'd1: j = (a != b);
      3'd4: j = lts;
      3'd5: j = !lts;
      3'd6: j = ltu;
      3'd7: j = !ltu;
      default: j = 1'b0;
    endcase
    return {j, r};
  endfunction

  function automatic logic [1:0] exp_ready();
    int w;
    bit free;
    if (req_valid == 2'b11) w = int'(m_prio);
    else if (req_valid[0]) w = 0;
    else if (req_valid[1]) w = 1;
    else w = -1;
    free = !m_full || rsp_ready[m_owner];
    if (w < 0 || !free) return 2'b00;
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    m_full = 0; m_owner = 0; m_prio = 0; m_jc = 0; m_res = 32'd0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_grant = 2'b00;
  endtask

  task automatic model_clock();
    logic [1:0]  r;
    logic [32:0] o;
    int          w;
    r = exp_ready();
    m_grant = r;
    if (r != 2'b00) begin
      w = r[1] ? 1 : 0;
      o = (w == 1) ? ref_alu(op1_1, op2_1, ctrl_1, sub[1], sign[1])
                   : ref_alu(op1_0, op2_0, ctrl_0, sub[0], sign[0]);
      m_res = o[31:0]; m_jc = o[32];
      m_full = 1; m_owner = w[0]; m_prio = !w[0];
      if (m_cnt[w] < CNT_MAX) m_cnt[w]++;
    end else if (m_full && rsp_ready[m_owner]) begin
      m_full = 0;
    end
  endtask

  task automatic check_all();
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready()});
    chk("rsp_valid", {30'd0, rsp_valid}, m_full ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
    chk("result", result, m_res);
    chk("jc", {31'd0, jc}, {31'd0, m_jc});
    chk("cnt0", {{(32-CNT_W){1'b0}}, cnt0}, m_cnt[0]);
    chk("cnt1", {{(32-CNT_W){1'b0}}, cnt1}, m_cnt[1]);
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input bit s, input bit sg);
    if (p == 0) begin op1_0 = a; op2_0 = b; ctrl_0 = c; end
    else        begin op1_1 = a; op2_1 = b; ctrl_1 = c; end
    sub[p] = s; sign[p] = sg;
  endtask

  task automatic rand_req(input int p);
    logic [31:0] a;
    a = $urandom;
    set_req(p, a, ($urandom_range(0, 3) == 0) ? a : $urandom, 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [31:0] held;

  initial begin
    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    sub = 2'b00; sign = 2'b00;
    set_req(0, 32'd0, 32'd0, 3'd0, 0, 0);
    set_req(1, 32'd0, 32'd0, 3'd0, 0, 0);
    #1 rst_n = 1'b0;
    do_reset();

    // Port 0 alone: 5 - 3.
    set_req(0, 32'd5, 32'd3, 3'd0, 1, 0);
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1 chk("tp1_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    #1;
    chk("tp1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("tp1_result", result, 32'd2);
    chk("tp1_jc", {31'd0, jc}, 32'd0);
    step();

    // Both ports every cycle: strict alternation from reset.
    do_reset();
    rand_req(0); rand_req(1);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk("alt_grant", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      rand_req(i % 2);
    end
    req_valid = 2'b00;
    #1;
    chk("alt_cnt0", {{(32-CNT_W){1'b0}}, cnt0}, 32'd2);
    chk("alt_cnt1", {{(32-CNT_W){1'b0}}, cnt1}, 32'd2);
    step();

    // Port 1 signed compares with -1 vs 1.
    set_req(1, 32'hFFFF_FFFF, 32'd1, 3'd4, 0, 0);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    #1;
    chk("br_xor", result, 32'hFFFF_FFFE);
    chk("br_lt", {31'd0, jc}, 32'd1);
    set_req(1, 32'hFFFF_FFFF, 32'd1, 3'd2, 0, 0);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    #1 chk("br_slt", result, 32'd1);
    set_req(1, 32'h8000_0000, 32'd4, 3'd5, 0, 1);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    #1 chk("br_sra", result, 32'hF800_0000);
    step();

    // Back-pressure: port 0 owns the slot and stalls; port 1 must wait.
    set_req(0, 32'd100, 32'd23, 3'd0, 1, 0);
    req_valid = 2'b01; rsp_ready = 2'b00;
    step();
    held = 32'd77;
    rand_req(1);
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
      chk("bp_result", result, held);
      step();
    end
    rsp_ready = 2'b01;
    #1 chk("bp_release", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00; rsp_ready = 2'b11;
    step();

    // Counter saturation on port 0.
    req_valid = 2'b01;
    for (int i = 0; i < 20; i++) begin
      rand_req(0);
      step();
    end
    req_valid = 2'b00;
    #1 chk("sat_cnt0", {{(32-CNT_W){1'b0}}, cnt0}, CNT_MAX);
    step();

    // Randomised traffic with legal requester behaviour.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && !m_grant[p]) begin
          if ($urandom_range(0, 7) == 0) req_valid[p] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          req_valid[p] = 1'b1;
          rand_req(p);
        end else begin
          req_valid[p] = 1'b0;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      step();
    end

    // Reset while port 1 holds an undelivered response.
    req_valid = 2'b00; rsp_ready = 2'b11;
    step();
    set_req(1, 32'd9, 32'd4, 3'd6, 0, 0);
    req_valid = 2'b10; rsp_ready = 2'b00;
    step();
    req_valid = 2'b00;
    #1 chk("rst_pre_valid", {30'd0, rsp_valid}, 32'd2);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_async_result", result, 32'd0);
    chk("rst_async_cnt1", {{(32-CNT_W){1'b0}}, cnt1}, 32'd0);
    rsp_ready = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
